// File: rtl/rca_config_bank.sv
// Double-buffered per-RCA port register-address config: shadow writes via valid/ready, commit to active when RCA idle.
// Reads have 1-cycle latency; cfg_ready drops only for an RCA whose commit is pending.
module rca_config_bank #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int REG_ADDR_W      = 5,
  localparam int RCA_W     = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1,
  localparam int MAX_PORTS = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS,
  localparam int PORT_W    = (MAX_PORTS > 1) ? $clog2(MAX_PORTS) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cfg_valid,
  output logic                                        cfg_ready,
  input  logic [RCA_W-1:0]                            cfg_rca,
  input  logic                                        cfg_is_dest,
  input  logic [PORT_W-1:0]                           cfg_port,
  input  logic [REG_ADDR_W-1:0]                       cfg_addr,
  input  logic                                        cfg_en,
  output logic                                        cfg_err,
  input  logic [NUM_RCAS-1:0]                         commit_req,
  input  logic [NUM_RCAS-1:0]                         rca_busy,
  output logic [NUM_RCAS-1:0]                         commit_pending,
  output logic [NUM_RCAS-1:0]                         commit_done,
  input  logic                                        rd_req,
  input  logic [RCA_W-1:0]                            rd_sel,
  output logic                                        rd_valid,
  output logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]   rd_src_addrs,
  output logic [NUM_READ_PORTS-1:0]                   rd_src_en,
  output logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0]  rd_dest_addrs,
  output logic [NUM_WRITE_PORTS-1:0]                  rd_dest_en
);

  typedef enum logic {IDLE, PENDING} state_t;

  typedef struct packed {
    logic [NUM_READ_PORTS-1:0][REG_ADDR_W-1:0]  src_addr;
    logic [NUM_READ_PORTS-1:0]                  src_en;
    logic [NUM_WRITE_PORTS-1:0][REG_ADDR_W-1:0] dst_addr;
    logic [NUM_WRITE_PORTS-1:0]                 dst_en;
  } bank_t;

  bank_t  shadow     [NUM_RCAS];
  bank_t  shadow_nxt [NUM_RCAS];
  bank_t  active     [NUM_RCAS];
  state_t state      [NUM_RCAS];
  bank_t  rd_bank;

  logic                rca_ok;
  logic                port_ok;
  logic                wr_fire;
  logic                err_fire;
  logic [NUM_RCAS-1:0] copy;

  always_comb begin
    cfg_ready = 1'b1;
    rca_ok    = 1'b0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      if (32'(cfg_rca) == i) begin
        cfg_ready = (state[i] == IDLE);
        rca_ok    = 1'b1;
      end
    end
  end

  assign port_ok  = cfg_is_dest ? (32'(cfg_port) < NUM_WRITE_PORTS) : (32'(cfg_port) < NUM_READ_PORTS);
  assign wr_fire  = cfg_valid & cfg_ready & rca_ok & port_ok;
  assign err_fire = cfg_valid & cfg_ready & ~(rca_ok & port_ok);

  // Commit copies from shadow_nxt so a same-cycle write is included in the copy.
  always_comb begin
    for (int i = 0; i < NUM_RCAS; i++) begin
      shadow_nxt[i] = shadow[i];
      if (wr_fire && (32'(cfg_rca) == i)) begin
        if (cfg_is_dest) begin
          for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (32'(cfg_port) == p) begin
              shadow_nxt[i].dst_addr[p] = cfg_addr;
              shadow_nxt[i].dst_en[p]   = cfg_en;
            end
          end
        end else begin
          for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (32'(cfg_port) == p) begin
              shadow_nxt[i].src_addr[p] = cfg_addr;
              shadow_nxt[i].src_en[p]   = cfg_en;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RCAS; i++) begin
      copy[i]           = ~rca_busy[i] & ((state[i] == PENDING) | commit_req[i]);
      commit_pending[i] = (state[i] == PENDING);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        state[i]  <= IDLE;
      end
      commit_done <= '0;
      cfg_err     <= 1'b0;
      rd_valid    <= 1'b0;
      rd_bank     <= '0;
    end else begin
      cfg_err     <= err_fire;
      commit_done <= copy;
      rd_valid    <= rd_req;
      for (int i = 0; i < NUM_RCAS; i++) begin
        shadow[i] <= shadow_nxt[i];
        if (copy[i]) active[i] <= shadow_nxt[i];
        case (state[i])
          IDLE:    if (commit_req[i] && rca_busy[i]) state[i] <= PENDING;
          PENDING: if (!rca_busy[i]) state[i] <= IDLE;
        endcase
      end
      // Reads sample active before this edge's commit lands; unknown RCAs read as zero.
      if (rd_req) begin
        rd_bank <= '0;
        for (int i = 0; i < NUM_RCAS; i++) begin
          if (32'(rd_sel) == i) rd_bank <= active[i];
        end
      end
    end
  end

  assign rd_src_addrs  = rd_bank.src_addr;
  assign rd_src_en     = rd_bank.src_en;
  assign rd_dest_addrs = rd_bank.dst_addr;
  assign rd_dest_en    = rd_bank.dst_en;

endmodule

// File: tb/tb_rca_config_bank.sv
// Bench for rca_config_bank with NUM_RCAS=5: directed scenarios plus randomized traffic against a reference model.
module tb_rca_config_bank;

  logic            clk;
  logic            rst;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [2:0]      cfg_rca;
  logic            cfg_is_dest;
  logic [2:0]      cfg_port;
  logic [4:0]      cfg_addr;
  logic            cfg_en;
  logic            cfg_err;
  logic [4:0]      commit_req;
  logic [4:0]      rca_busy;
  logic [4:0]      commit_pending;
  logic [4:0]      commit_done;
  logic            rd_req;
  logic [2:0]      rd_sel;
  logic            rd_valid;
  logic [4:0][4:0] rd_src_addrs;
  logic [4:0]      rd_src_en;
  logic [3:0][4:0] rd_dest_addrs;
  logic [3:0]      rd_dest_en;

  rca_config_bank #(
    .NUM_RCAS(5), .NUM_READ_PORTS(5), .NUM_WRITE_PORTS(4), .REG_ADDR_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_rca(cfg_rca),
    .cfg_is_dest(cfg_is_dest), .cfg_port(cfg_port), .cfg_addr(cfg_addr),
    .cfg_en(cfg_en), .cfg_err(cfg_err),
    .commit_req(commit_req), .rca_busy(rca_busy),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid),
    .rd_src_addrs(rd_src_addrs), .rd_src_en(rd_src_en),
    .rd_dest_addrs(rd_dest_addrs), .rd_dest_en(rd_dest_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: plain per-RCA shadow/active tables and a pending flag.
  logic [4:0][4:0] sh_sa [5];
  logic [4:0]      sh_se [5];
  logic [3:0][4:0] sh_da [5];
  logic [3:0]      sh_de [5];
  logic [4:0][4:0] ac_sa [5];
  logic [4:0]      ac_se [5];
  logic [3:0][4:0] ac_da [5];
  logic [3:0]      ac_de [5];
  logic [4:0]      pend = '0;
  logic [4:0]      e_done;
  logic            e_err;
  logic            e_rv;
  logic [4:0][4:0] e_sa;
  logic [4:0]      e_se;
  logic [3:0][4:0] e_da;
  logic [3:0]      e_de;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    if (cfg_rca < 3'd5) return !pend[cfg_rca];
    return 1'b1;
  endfunction

  task automatic model_step();
    int  r;
    int  p;
    logic acc;
    logic ok;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        sh_sa[i] = '0; sh_se[i] = '0; sh_da[i] = '0; sh_de[i] = '0;
        ac_sa[i] = '0; ac_se[i] = '0; ac_da[i] = '0; ac_de[i] = '0;
      end
      pend = '0; e_done = '0; e_err = 1'b0; e_rv = 1'b0;
      e_sa = '0; e_se = '0; e_da = '0; e_de = '0;
      return;
    end
    e_rv = rd_req;
    if (rd_req) begin
      r = int'(rd_sel);
      if (r < 5) begin
        e_sa = ac_sa[r]; e_se = ac_se[r]; e_da = ac_da[r]; e_de = ac_de[r];
      end else begin
        e_sa = '0; e_se = '0; e_da = '0; e_de = '0;
      end
    end
    r   = int'(cfg_rca);
    p   = int'(cfg_port);
    acc = cfg_valid && m_ready();
    ok  = (r < 5) && (cfg_is_dest ? (p < 4) : (p < 5));
    e_err = acc && !ok;
    if (acc && ok) begin
      if (cfg_is_dest) begin sh_da[r][p] = cfg_addr; sh_de[r][p] = cfg_en; end
      else             begin sh_sa[r][p] = cfg_addr; sh_se[r][p] = cfg_en; end
    end
    e_done = '0;
    for (int i = 0; i < 5; i++) begin
      logic do_copy;
      do_copy = 1'b0;
      if (pend[i]) begin
        if (!rca_busy[i]) begin do_copy = 1'b1; pend[i] = 1'b0; end
      end else if (commit_req[i]) begin
        if (rca_busy[i]) pend[i] = 1'b1;
        else             do_copy = 1'b1;
      end
      if (do_copy) begin
        ac_sa[i] = sh_sa[i]; ac_se[i] = sh_se[i]; ac_da[i] = sh_da[i]; ac_de[i] = sh_de[i];
        e_done[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("cfg_err", cfg_err, e_err);
    chk("commit_done", commit_done, e_done);
    chk("commit_pending", commit_pending, pend);
    chk("rd_valid", rd_valid, e_rv);
    chk("rd_src_addrs", rd_src_addrs, e_sa);
    chk("rd_src_en", rd_src_en, e_se);
    chk("rd_dest_addrs", rd_dest_addrs, e_da);
    chk("rd_dest_en", rd_dest_en, e_de);
  endtask

  // Inputs are set just after a falling edge; this checks cfg_ready, steps the model at the rising edge, then compares.
  task automatic cycle();
    #1;
    if (!rst) chk("cfg_ready", cfg_ready, m_ready());
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clr();
    cfg_valid = 1'b0; commit_req = '0; rd_req = 1'b0;
  endtask

  task automatic wr(input int rca, input logic dest, input int port, input int addr, input logic en);
    cfg_valid = 1'b1; cfg_rca = 3'(rca); cfg_is_dest = dest;
    cfg_port = 3'(port); cfg_addr = 5'(addr); cfg_en = en;
  endtask

  task automatic rd(input int rca);
    rd_req = 1'b1; rd_sel = 3'(rca);
  endtask

  initial begin
    rst = 1'b1; clr(); cfg_rca = '0; cfg_is_dest = 1'b0; cfg_port = '0;
    cfg_addr = '0; cfg_en = 1'b0; rca_busy = '0; rd_sel = '0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    #1 chk("lit_reset_ready", cfg_ready, 1);
    chk("lit_reset_pending", commit_pending, 0);
    chk("lit_reset_rd_valid", rd_valid, 0);

    // Write, commit, then read RCA1.
    wr(1, 1'b0, 2, 17, 1'b1); cycle(); clr();
    commit_req = 5'b00010; cycle(); clr();
    chk("lit_done1", commit_done, 5'b00010);
    rd(1); cycle(); clr();
    chk("lit_rd_valid", rd_valid, 1);
    chk("lit_src_addrs", rd_src_addrs, {5'd0, 5'd0, 5'd17, 5'd0, 5'd0});
    chk("lit_src_en", rd_src_en, 5'b00100);
    chk("lit_dest_en", rd_dest_en, 0);

    // Busy commit on RCA2 goes pending; a repeat request merges.
    rca_busy = 5'b00100; commit_req = 5'b00100; cycle(); clr();
    chk("lit_pending2", commit_pending, 5'b00100);
    wr(2, 1'b0, 0, 3, 1'b1);
    #1 chk("lit_ready_blocked", cfg_ready, 0);
    cycle(); clr();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) commit_req = 5'b00100;
      cycle(); clr();
    end
    rca_busy = '0; cycle();
    chk("lit_done2", commit_done, 5'b00100);
    chk("lit_pending2_clear", commit_pending, 0);
    cycle();
    chk("lit_done2_once", commit_done, 0);

    // Out-of-range writes flag cfg_err and change nothing.
    wr(0, 1'b1, 4, 21, 1'b1); cycle(); clr();
    chk("lit_err_port", cfg_err, 1);
    wr(5, 1'b0, 0, 21, 1'b1); cycle(); clr();
    chk("lit_err_rca", cfg_err, 1);
    commit_req = 5'b11111; cycle(); clr();
    for (int i = 0; i < 8; i++) begin rd(i); cycle(); clr(); end
    chk("lit_rd_oob_zero", rd_src_addrs, 0);

    // Same-cycle write+commit+read of RCA0: read sees old active.
    wr(0, 1'b1, 0, 9, 1'b1); commit_req = 5'b00001; rd(0); cycle(); clr();
    chk("lit_same_cycle_old", rd_dest_addrs[0], 0);
    chk("lit_same_cycle_done", commit_done, 5'b00001);
    rd(0); cycle(); clr();
    chk("lit_same_cycle_new", rd_dest_addrs[0], 9);

    // Uncommitted write is invisible until commit.
    wr(3, 1'b0, 0, 7, 1'b1); cycle(); clr();
    for (int k = 0; k < 3; k++) begin rd(3); cycle(); clr(); end
    chk("lit_uncommitted", rd_src_addrs[0], 0);
    commit_req = 5'b01000; cycle(); clr();
    rd(3); cycle(); clr();
    chk("lit_committed", rd_src_addrs[0], 7);

    // Reset while RCA1 pending drops the commit.
    rca_busy = 5'b00010; commit_req = 5'b00010; cycle(); clr();
    chk("lit_pending1", commit_pending, 5'b00010);
    rst = 1'b1; cycle(); rst = 1'b0; rca_busy = '0;
    chk("lit_rst_pending", commit_pending, 0);
    chk("lit_rst_done", commit_done, 0);
    cycle();
    chk("lit_rst_no_done", commit_done, 0);
    rd(1); cycle(); clr();
    chk("lit_rst_rd_src", rd_src_addrs, 0);
    chk("lit_rst_rd_en", rd_src_en, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_valid   = $urandom_range(0, 1);
      cfg_rca     = 3'($urandom_range(0, 7));
      cfg_is_dest = $urandom_range(0, 1);
      cfg_port    = 3'($urandom_range(0, 7));
      cfg_addr    = 5'($urandom);
      cfg_en      = $urandom_range(0, 1);
      rd_req      = $urandom_range(0, 1);
      rd_sel      = 3'($urandom_range(0, 7));
      for (int i = 0; i < 5; i++) begin
        commit_req[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) rca_busy[i] = ~rca_busy[i];
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_config_bank.md
Name: rca_config_bank

Overview:
- Parametrised, double-buffered register-address configuration store for the reconfigurable accelerator (RCA) units.
- Each RCA has a shadow bank and an active bank. Each bank holds, per port, a source/destination register address and an enable bit.
- Software-driven config writes land in the shadow bank through a valid/ready handshake. A per-RCA commit copies shadow to active once that RCA is not busy.
- Issue logic reads the active bank of a selected RCA with registered, one-cycle latency.

Parameters:
- NUM_RCAS, 4, number of accelerator units (≥1, need not be a power of two)
- NUM_READ_PORTS, 5, source-register ports per RCA
- NUM_WRITE_PORTS, 4, destination-register ports per RCA
- REG_ADDR_W, 5, register address width
- Derived: RCA_W = max(1, clog2(NUM_RCAS)); PORT_W = max(1, clog2(max(NUM_READ_PORTS, NUM_WRITE_PORTS)))

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready
- cfg_rca  in  RCA_W  target RCA
- cfg_is_dest  in  1  0 = source port entry, 1 = destination port entry
- cfg_port  in  PORT_W  port index
- cfg_addr  in  REG_ADDR_W  register address
- cfg_en  in  1  port enable bit written with cfg_addr
- cfg_err  out  1  one-cycle pulse: accepted write had out-of-range index
- commit_req  in  NUM_RCAS  per-RCA commit request
- rca_busy  in  NUM_RCAS  RCA executing; active bank must not change
- commit_pending  out  NUM_RCAS  commit waiting for RCA idle
- commit_done  out  NUM_RCAS  one-cycle pulse after shadow→active copy
- rd_req  in  1  read request
- rd_sel  in  RCA_W  RCA to read
- rd_valid  out  1  read data valid, one-cycle pulse
- rd_src_addrs  out  NUM_READ_PORTS x REG_ADDR_W  active source addresses
- rd_src_en  out  NUM_READ_PORTS  active source enables
- rd_dest_addrs  out  NUM_WRITE_PORTS x REG_ADDR_W  active destination addresses
- rd_dest_en  out  NUM_WRITE_PORTS  active destination enables

Behaviour:
- Interface decision: reset rst, synchronous, active-high; clock clk.
- Reset state:
  - all shadow and active addresses and enables = 0
  - every per-RCA FSM in IDLE
  - commit_pending = 0, commit_done = 0, cfg_err = 0
  - rd_valid = 0; all rd_* data outputs = 0
- Reset while PENDING drops the commit: no copy, no commit_done pulse.
- Per-RCA FSM (IDLE, PENDING):
  - IDLE, commit_req[i] = 1, rca_busy[i] = 0: copy shadow[i]→active[i] at this edge; commit_done[i] = 1 next cycle; stay IDLE.
  - IDLE, commit_req[i] = 1, rca_busy[i] = 1: go PENDING.
  - PENDING, rca_busy[i] = 0 at an edge: copy; go IDLE; commit_done[i] pulses next cycle.
  - commit_req[i] while PENDING is ignored (merged; exactly one copy and one done pulse).
  - commit_pending[i] = (state == PENDING).
- cfg_ready is combinational:
  - cfg_rca < NUM_RCAS: cfg_ready = (state[cfg_rca] == IDLE). The shadow is frozen while its commit is pending.
  - cfg_rca ≥ NUM_RCAS: cfg_ready = 1, so the error path can complete.
  - No dependence on cfg_valid.
- Accepted write, all indices in range (cfg_rca < NUM_RCAS; cfg_port < NUM_READ_PORTS for src or < NUM_WRITE_PORTS for dest):
  - updates shadow address and enable at the edge
  - cfg_err stays 0
- Accepted write, any index out of range: no state change; cfg_err = 1 in the next cycle.
- Accepted write and an immediate commit (IDLE, not busy) to the same RCA in the same cycle: active receives the post-write shadow value.
- Read:
  - rd_req at an edge registers the active[rd_sel] contents into the rd_* outputs; rd_valid = 1 the next cycle.
  - Without rd_req, rd_valid = 0 and the data outputs hold their last values.
  - Read and copy to the same RCA in the same cycle: the read returns the pre-commit active values.
  - rd_sel ≥ NUM_RCAS returns all zeros with rd_valid = 1.
- Active banks change only through commit. Config writes never affect rd_* directly.
- Commits on different RCAs are independent and may complete in the same cycle.

Test Plan:
- Reset, then write RCA1 src port2 addr=5'd17 en=1, commit_req[1] with busy=0, rd_req rd_sel=1 → cycle+1: commit_done[1]; after read: rd_src_addrs[2] = 17, rd_src_en[2] = 1, all other entries 0.
- rca_busy[2] = 1, commit_req[2] → commit_pending[2] = 1 and cfg_ready = 0 for cfg_rca = 2. Drop busy after 5 cycles → one commit_done[2] pulse and pending clears. A second commit_req during pending yields no extra pulse.
- Write dest port4 (NUM_WRITE_PORTS = 4) and, separately, cfg_rca = 3'd5 with NUM_RCAS = 5 → cfg_err pulses each time; read of every RCA shows shadow and active unchanged.
- Same cycle: write RCA0 dest port0 addr = 9 plus commit_req[0], busy = 0, plus rd_req rd_sel = 0 → read shows the old value 0; the next read shows 9.
- Write RCA3 src port0 addr = 7 with no commit → reads of RCA3 keep returning 0 until a commit is issued.
- Assert rst while RCA1 is PENDING → pending clears, no commit_done, RCA1 reads all zeros.
